rover_drive_sequencer: RTL and testbench

Command-level controller that sits in front of the two-channel motor PWM generator, which takes 3-bit speed codes and drives PIN_EN0/PIN_EN1.
- Accepts target speed and direction per side through a valid/ready handshake.
- Ramps the applied speed codes one step at a time.
- On a direction reversal, ramps down to zero, waits a dead time, then flips direction.
- Cuts drive and locks out when a side's current-sense comparator reports a sustained overcurrent (stall).

---
 rtl/drive_seq_pkg.sv | 36 +++
 rtl/drive_ramp_channel.sv | 53 +++++
 rtl/rover_drive_sequencer.sv | 157 +++++++++++++++
 tb/tb_rover_drive_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drive_seq_pkg: shared widths, states and helpers for the drive sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package drive_seq_pkg;

   localparam int                 SPEED_W   = 3;
   localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
   localparam logic               DIR_FWD   = 1'b1;
   localparam logic               DIR_REV   = 1'b0;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RAMP  = 3'd1;
   localparam logic [2:0] ST_DWELL = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_STALL = 3'd4;

   // One code step toward the target, never wrapping past 0 or SPEED_MAX.
   function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                      input logic [SPEED_W-1:0] tgt);
      logic [SPEED_W-1:0] res;
      res = cur;
      if ((cur < tgt) && (cur != SPEED_MAX))
         res = cur + 1'b1;
      else if ((cur > tgt) && (cur != '0))
         res = cur - 1'b1;
      return res;
   endfunction

   function automatic int tmr_width(input int max_ticks);
      return (max_ticks > 1) ? $clog2(max_ticks) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/drive_ramp_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drive_ramp_channel: one side's applied speed register and stall counter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module drive_ramp_channel
   import drive_seq_pkg::*;
#(
   parameter int STALL_TICKS = 20_000_000
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_step,
   input  logic               i_force_zero,
   input  logic               i_oc,
   input  logic [SPEED_W-1:0] i_target,
   output logic [SPEED_W-1:0] o_speed,
   output logic [SPEED_W-1:0] o_speed_step,
   output logic               o_stall_detect
);

   localparam int                c_CNT_W      = tmr_width(STALL_TICKS);
   localparam logic [c_CNT_W-1:0] c_STALL_LAST = c_CNT_W'(STALL_TICKS - 1);

   logic [SPEED_W-1:0] r_speed;
   logic [c_CNT_W-1:0] r_oc_cnt;
   logic               w_oc_active;

   // Overcurrent only counts while the side is actually being driven.
   assign w_oc_active    = i_oc && (r_speed != '0);
   assign o_stall_detect = w_oc_active && (r_oc_cnt == c_STALL_LAST);
   assign o_speed_step   = step_toward(r_speed, i_target);
   assign o_speed        = r_speed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_speed  <= '0;
         r_oc_cnt <= '0;
      end else begin
         if (i_force_zero)
            r_speed <= '0;
         else if (i_step)
            r_speed <= o_speed_step;

         if (!w_oc_active || o_stall_detect)
            r_oc_cnt <= '0;
         else
            r_oc_cnt <= r_oc_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rover_drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rover_drive_sequencer: ramped, reversal-safe, stall-protected drive control|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rover_drive_sequencer
   import drive_seq_pkg::*;
#(
   parameter int RAMP_TICKS    = 1_000_000,
   parameter int DEAD_TICKS    = 5_000_000,
   parameter int STALL_TICKS   = 20_000_000,
   parameter int LOCKOUT_TICKS = 100_000_000
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SPEED_W-1:0] cmd_speed_left,
   input  logic [SPEED_W-1:0] cmd_speed_right,
   input  logic               cmd_dir_left,
   input  logic               cmd_dir_right,
   input  logic               oc_left,
   input  logic               oc_right,
   output logic [SPEED_W-1:0] speed_left,
   output logic [SPEED_W-1:0] speed_right,
   output logic               dir_left,
   output logic               dir_right,
   output logic               busy,
   output logic               stall
);

   localparam int c_MAX_A   = (RAMP_TICKS > DEAD_TICKS) ? RAMP_TICKS : DEAD_TICKS;
   localparam int c_MAX_B   = (STALL_TICKS > LOCKOUT_TICKS) ? STALL_TICKS : LOCKOUT_TICKS;
   localparam int c_TMR_W   = tmr_width((c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B);

   logic [2:0]         r_state, w_state_nxt;
   logic [c_TMR_W-1:0] r_tmr;
   logic [SPEED_W-1:0] r_tgt_l, r_tgt_r;
   logic               r_tdir_l, r_tdir_r, r_dir_l, r_dir_r, r_busy, r_stall;
   logic [SPEED_W-1:0] w_eff_l, w_eff_r, w_step_l, w_step_r, w_post_l, w_post_r;
   logic               w_det_l, w_det_r, w_stall_det, w_accept, w_step, w_tmr_clr;
   logic               w_mis_l, w_mis_r, w_to_dwell, w_at_tgt;
   logic               w_ramp_end, w_dead_end, w_lock_end;

   assign w_mis_l = (r_tdir_l != r_dir_l);
   assign w_mis_r = (r_tdir_r != r_dir_r);
   assign w_eff_l = w_mis_l ? '0 : r_tgt_l;
   assign w_eff_r = w_mis_r ? '0 : r_tgt_r;

   assign w_ramp_end = (r_tmr == c_TMR_W'(RAMP_TICKS - 1));
   assign w_dead_end = (r_tmr == c_TMR_W'(DEAD_TICKS - 1));
   assign w_lock_end = (r_tmr == c_TMR_W'(LOCKOUT_TICKS - 1));

   assign w_stall_det = w_det_l || w_det_r;
   assign cmd_ready   = ((r_state == ST_IDLE) || (r_state == ST_RAMP) || (r_state == ST_RUN))
                        && !w_stall_det;
   assign w_accept    = cmd_valid && cmd_ready;
   assign w_step      = (r_state == ST_RAMP) && w_ramp_end && !w_accept && !w_stall_det;

   // Transition decisions look at the speeds as they will be after this edge.
   assign w_post_l   = w_step ? w_step_l : speed_left;
   assign w_post_r   = w_step ? w_step_r : speed_right;
   assign w_to_dwell = (w_mis_l || w_mis_r) && (!w_mis_l || (w_post_l == '0))
                       && (!w_mis_r || (w_post_r == '0));
   assign w_at_tgt   = (w_post_l == w_eff_l) && (w_post_r == w_eff_r);

   always_comb begin
      w_state_nxt = r_state;
      if (w_stall_det)
         w_state_nxt = ST_STALL;
      else begin
         case (r_state)
            ST_IDLE, ST_RUN: if (w_accept) w_state_nxt = ST_RAMP;
            ST_RAMP: begin
               if (w_accept)        w_state_nxt = ST_RAMP;
               else if (w_to_dwell) w_state_nxt = ST_DWELL;
               else if (w_at_tgt)
                  w_state_nxt = ((w_post_l == '0) && (w_post_r == '0)) ? ST_IDLE : ST_RUN;
            end
            ST_DWELL: if (w_dead_end) w_state_nxt = ST_RAMP;
            ST_STALL: if (w_lock_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_tmr_clr = (w_state_nxt != r_state) || w_accept || (r_state == ST_IDLE)
                      || (r_state == ST_RUN) || ((r_state == ST_RAMP) && w_ramp_end);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_tmr    <= '0;
         r_tgt_l  <= '0;
         r_tgt_r  <= '0;
         r_tdir_l <= DIR_FWD;
         r_tdir_r <= DIR_FWD;
         r_dir_l  <= DIR_FWD;
         r_dir_r  <= DIR_FWD;
         r_busy   <= 1'b0;
         r_stall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_DWELL)
                    || (w_state_nxt == ST_STALL);
         r_tmr   <= w_tmr_clr ? '0 : r_tmr + 1'b1;
         if (w_stall_det) begin
            r_tgt_l  <= '0;
            r_tgt_r  <= '0;
            r_tdir_l <= r_dir_l;
            r_tdir_r <= r_dir_r;
            r_stall  <= 1'b1;
         end else if (w_accept) begin
            r_tgt_l  <= cmd_speed_left;
            r_tgt_r  <= cmd_speed_right;
            r_tdir_l <= cmd_dir_left;
            r_tdir_r <= cmd_dir_right;
            r_stall  <= 1'b0;
         end
         if ((r_state == ST_DWELL) && w_dead_end && !w_stall_det) begin
            r_dir_l <= r_tdir_l;
            r_dir_r <= r_tdir_r;
         end
      end
   end

   drive_ramp_channel #(.STALL_TICKS(STALL_TICKS)) u_chan_left (
      .clk            (clock),
      .rst            (reset),
      .i_step         (w_step),
      .i_force_zero   (w_stall_det),
      .i_oc           (oc_left),
      .i_target       (w_eff_l),
      .o_speed        (speed_left),
      .o_speed_step   (w_step_l),
      .o_stall_detect (w_det_l)
   );

   drive_ramp_channel #(.STALL_TICKS(STALL_TICKS)) u_chan_right (
      .clk            (clock),
      .rst            (reset),
      .i_step         (w_step),
      .i_force_zero   (w_stall_det),
      .i_oc           (oc_right),
      .i_target       (w_eff_r),
      .o_speed        (speed_right),
      .o_speed_step   (w_step_r),
      .o_stall_detect (w_det_r)
   );

   assign dir_left  = r_dir_l;
   assign dir_right = r_dir_r;
   assign busy      = r_busy;
   assign stall     = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_rover_drive_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rover_drive_sequencer: scoreboard bench for rover_drive_sequencer.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rover_drive_sequencer;
   import drive_seq_pkg::*;

   localparam int c_RAMP = 4, c_DEAD = 8, c_STALL = 16, c_LOCK = 32;

   logic       clock = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_speed_left = '0, cmd_speed_right = '0;
   logic       cmd_dir_left = 1'b1, cmd_dir_right = 1'b1, oc_left = 1'b0, oc_right = 1'b0;
   logic [2:0] speed_left, speed_right;
   logic       dir_left, dir_right, busy, stall;

   typedef struct {
      int         cyc;
      logic [2:0] sl;
      logic [2:0] sr;
      logic       dl;
      logic       dr;
      logic       busy;
      logic       stall;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   rover_drive_sequencer #(
      .RAMP_TICKS(c_RAMP), .DEAD_TICKS(c_DEAD), .STALL_TICKS(c_STALL), .LOCKOUT_TICKS(c_LOCK)
   ) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_speed_left(cmd_speed_left), .cmd_speed_right(cmd_speed_right),
      .cmd_dir_left(cmd_dir_left), .cmd_dir_right(cmd_dir_right),
      .oc_left(oc_left), .oc_right(oc_right),
      .speed_left(speed_left), .speed_right(speed_right),
      .dir_left(dir_left), .dir_right(dir_right), .busy(busy), .stall(stall)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: each entry names the edge after which the outputs must match.
   always @(negedge clock) begin
      exp_t e;
      while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
         e = sb.pop_front();
         n_checks++;
         if ((e.cyc != cyc) || ({speed_left, speed_right, dir_left, dir_right, busy, stall}
                                !== {e.sl, e.sr, e.dl, e.dr, e.busy, e.stall})) begin
            n_fail++;
            $display("FAIL sb_edge%0d at %0d: got sl=%0d sr=%0d dl=%b dr=%b busy=%b stall=%b, want sl=%0d sr=%0d dl=%b dr=%b busy=%b stall=%b",
                     e.cyc, cyc, speed_left, speed_right, dir_left, dir_right, busy, stall,
                     e.sl, e.sr, e.dl, e.dr, e.busy, e.stall);
         end
      end
   end

   function automatic void push(input int c, input int sl, input int sr,
                                input logic dl, input logic dr, input logic bsy, input logic stl);
      exp_t e;
      e.cyc = c; e.sl = 3'(sl); e.sr = 3'(sr); e.dl = dl; e.dr = dr; e.busy = bsy; e.stall = stl;
      sb.push_back(e);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_cmd(input int l, input int r, input logic dl, input logic dr, output int acc);
      cmd_speed_left  = 3'(l);
      cmd_speed_right = 3'(r);
      cmd_dir_left    = dl;
      cmd_dir_right   = dr;
      cmd_valid       = 1'b1;
      acc             = cyc + 1;
      tick(1);
      cmd_valid       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      n_checks++;
      if ({speed_left, speed_right} !== 6'd0) begin
         n_fail++; $display("FAIL reset_speeds got %0d/%0d want 0/0", speed_left, speed_right);
      end
      n_checks++;
      if ({dir_left, dir_right} !== 2'b11) begin
         n_fail++; $display("FAIL reset_dirs got %b%b want 11", dir_left, dir_right);
      end
      n_checks++;
      if ({busy, stall, cmd_ready} !== 3'b001) begin
         n_fail++; $display("FAIL reset_flags busy/stall/ready got %b%b%b want 001", busy, stall, cmd_ready);
      end
   endtask

   task automatic test_ramp_up();
      int a;
      send_cmd(5, 3, DIR_FWD, DIR_FWD, a);
      for (int k = 0; k <= 20; k++)
         push(a + k, (k / 4 > 5) ? 5 : k / 4, (k / 4 > 3) ? 3 : k / 4, 1'b1, 1'b1, (k < 20), 1'b0);
      tick(22);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL ramp_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_reverse();
      int a;
      send_cmd(3, 3, DIR_FWD, DIR_FWD, a);
      tick(10);
      n_checks++;
      if ({speed_left, speed_right, busy} !== {3'd3, 3'd3, 1'b0}) begin
         n_fail++; $display("FAIL settle_3_3 got %0d/%0d busy=%b want 3/3 busy=0", speed_left, speed_right, busy);
      end
      send_cmd(3, 3, DIR_REV, DIR_FWD, a);
      for (int k = 0; k <= 32; k++)
         push(a + k, (k < 12) ? 3 - k / 4 : (k < 24) ? 0 : (k - 20) / 4, 3,
              (k < 20), 1'b1, (k < 32), 1'b0);
      tick(34);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL reverse_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_retarget();
      int a1, a2;
      send_cmd(7, 7, DIR_REV, DIR_FWD, a1);
      for (int k = 0; k <= 4; k++)
         push(a1 + k, (k < 4) ? 3 : 4, (k < 4) ? 3 : 4, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(4);
      send_cmd(2, 2, DIR_REV, DIR_FWD, a2);
      for (int k = 0; k <= 8; k++)
         push(a2 + k, (k < 4) ? 4 : (k < 8) ? 3 : 2, (k < 4) ? 4 : (k < 8) ? 3 : 2,
              1'b0, 1'b1, (k < 8), 1'b0);
      tick(10);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL retarget_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_dwell_handshake();
      int a, acc, b;
      send_cmd(2, 2, DIR_FWD, DIR_FWD, a);
      for (int k = 0; k <= 16; k++)
         push(a + k, (k < 4) ? 2 : (k < 8) ? 1 : 0, 2, !(k < 16), 1'b1, 1'b1, 1'b0);
      tick(9);
      cmd_speed_left = 3'd1; cmd_speed_right = 3'd1;
      cmd_dir_left = DIR_FWD; cmd_dir_right = DIR_FWD;
      cmd_valid = 1'b1;
      acc = -1;
      b   = a + 17;
      for (int i = 0; (i < 20) && (acc < 0); i++) begin
         @(negedge clock);
         if (cmd_ready) acc = cyc + 1;
      end
      for (int k = 0; k <= 4; k++)
         push(b + k, (k < 4) ? 0 : 1, (k < 4) ? 2 : 1, 1'b1, 1'b1, (k < 4), 1'b0);
      tick(1);
      cmd_valid = 1'b0;
      n_checks++;
      if (acc != b) begin n_fail++; $display("FAIL dwell_accept_edge got %0d want %0d", acc, b); end
      tick(6);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL dwell_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_stall();
      int a, e0, s, lows;
      send_cmd(5, 1, DIR_FWD, DIR_FWD, a);
      tick(18);
      e0 = cyc;
      s  = e0 + 16;
      push(e0 + 15, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0);
      push(s,       0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      push(s + 31,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      push(s + 32,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      oc_left = 1'b1;
      tick(15);
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_detect_ready got %b want 0", cmd_ready); end
      cmd_speed_left = 3'd3; cmd_speed_right = 3'd3; cmd_valid = 1'b1;
      tick(1);
      oc_left = 1'b0; cmd_valid = 1'b0;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_beats_cmd stall got %b want 1", stall); end
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (cmd_ready) break;
         lows++;
      end
      n_checks++;
      if (lows != c_LOCK) begin n_fail++; $display("FAIL lockout_len got %0d want %0d", lows, c_LOCK); end
      tick(1);
      send_cmd(2, 2, DIR_FWD, DIR_FWD, a);
      for (int k = 0; k <= 8; k++)
         push(a + k, k / 4, k / 4, 1'b1, 1'b1, (k < 8), 1'b0);
      tick(10);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_oc_glitch();
      int g;
      g = cyc;
      for (int k = 1; k <= 32; k++)
         push(g + k, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      oc_left = 1'b1;
      tick(15);
      oc_left = 1'b0;
      tick(1);
      oc_left = 1'b1;
      tick(15);
      oc_left = 1'b0;
      tick(2);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL glitch_drain pending %0d want 0", sb.size()); end
   endtask

   task automatic test_reset_midramp();
      int a;
      send_cmd(7, 7, DIR_FWD, DIR_FWD, a);
      push(a + 4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      n_checks++;
      if ({speed_left, speed_right, dir_left, dir_right, busy, stall, cmd_ready}
          !== {3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL midramp_reset got sl=%0d sr=%0d dl=%b dr=%b busy=%b stall=%b ready=%b want 0 0 1 1 0 0 1",
                  speed_left, speed_right, dir_left, dir_right, busy, stall, cmd_ready);
      end
      send_cmd(1, 1, DIR_FWD, DIR_FWD, a);
      for (int k = 0; k <= 4; k++)
         push(a + k, (k < 4) ? 0 : 1, (k < 4) ? 0 : 1, 1'b1, 1'b1, (k < 4), 1'b0);
      tick(6);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL midramp_drain pending %0d want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_reverse();
      test_retarget();
      test_dwell_handshake();
      test_stall();
      test_oc_glitch();
      test_reset_midramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
